// File: rtl/msrh_lrq.sv
// msrh_lrq: LSU load request queue tracking L1D line misses to L2; perf counters under MSRH_LRQ_PERF_CNT_EN
module msrh_lrq #(
  parameter int LRQ_ENTRY_SIZE = 8,
  parameter int LSU_INST_NUM   = 2,
  parameter int PADDR_W        = 40,
  parameter int LINE_OFS_W     = 6
) (
  input  logic                                         i_clk,
  input  logic                                         i_reset,
  input  logic [LSU_INST_NUM-1:0]                      i_req_valid,
  input  logic [LSU_INST_NUM-1:0][PADDR_W-1:0]         i_req_paddr,
  output logic [LSU_INST_NUM-1:0]                      o_resp_full,
  output logic [LSU_INST_NUM-1:0]                      o_resp_conflict,
  output logic [LSU_INST_NUM-1:0]                      o_resp_assigned,
  output logic [LSU_INST_NUM-1:0][LRQ_ENTRY_SIZE-1:0]  o_resp_index_oh,
  output logic                                         o_l2_req_valid,
  input  logic                                         i_l2_req_ready,
  output logic [PADDR_W-1:0]                           o_l2_req_paddr,
  output logic [$clog2(LRQ_ENTRY_SIZE)-1:0]            o_l2_req_tag,
  input  logic                                         i_l2_resp_valid,
  input  logic [$clog2(LRQ_ENTRY_SIZE)-1:0]            i_l2_resp_tag,
  output logic                                         o_lrq_resolve_valid,
  output logic [LRQ_ENTRY_SIZE-1:0]                    o_lrq_resolve_index_oh,
  output logic [31:0]                                  o_perf_alloc_cnt,
  output logic [31:0]                                  o_perf_full_cnt
);
  localparam int IDX_W  = $clog2(LRQ_ENTRY_SIZE);
  localparam int LINE_W = PADDR_W - LINE_OFS_W;
  typedef enum logic [1:0] {FREE, REQ_WAIT, RESP_WAIT} state_t;
  state_t state [LRQ_ENTRY_SIZE];
  logic [LRQ_ENTRY_SIZE-1:0][LINE_W-1:0] line_q, cur_line;
  logic [LRQ_ENTRY_SIZE-1:0] valid, cur_valid, hit, free_oh, alloc, req_wait;
  logic found, lock_valid, resp_hit;
  logic [IDX_W-1:0] lock_idx, first_idx;
  logic [LINE_W-1:0] req_line;
  always_comb begin
    valid = '0;
    req_wait = '0;
    for (int e = 0; e < LRQ_ENTRY_SIZE; e++) begin
      valid[e] = state[e] != FREE;
      req_wait[e] = state[e] == REQ_WAIT;
    end
  end
  // Pipes see the allocations of lower pipes through cur_valid/cur_line.
  always_comb begin
    cur_valid = valid;
    cur_line = line_q;
    alloc = '0;
    hit = '0;
    free_oh = '0;
    found = 1'b0;
    req_line = '0;
    o_resp_full = '0;
    o_resp_conflict = '0;
    o_resp_assigned = '0;
    o_resp_index_oh = '0;
    for (int p = 0; p < LSU_INST_NUM; p++) begin
      req_line = i_req_paddr[p][PADDR_W-1:LINE_OFS_W];
      found = 1'b0;
      for (int e = 0; e < LRQ_ENTRY_SIZE; e++) begin
        hit[e] = cur_valid[e] && cur_line[e] == req_line;
        free_oh[e] = !cur_valid[e] && !found;
        found = found | !cur_valid[e];
      end
      if (i_req_valid[p]) begin
        o_resp_conflict[p] = |hit;
        o_resp_index_oh[p] = hit;
        o_resp_assigned[p] = !(|hit) && found;
        o_resp_full[p] = !(|hit) && !found;
        if (!(|hit) && found) begin
          alloc = alloc | free_oh;
          cur_valid = cur_valid | free_oh;
          for (int e = 0; e < LRQ_ENTRY_SIZE; e++)
            if (free_oh[e]) cur_line[e] = req_line;
        end
      end
    end
  end
  always_comb begin
    first_idx = '0;
    for (int e = LRQ_ENTRY_SIZE - 1; e >= 0; e--)
      if (req_wait[e]) first_idx = IDX_W'(e);
  end
  assign o_l2_req_valid = |req_wait;
  assign o_l2_req_tag = lock_valid ? lock_idx : first_idx;
  assign o_l2_req_paddr = {line_q[o_l2_req_tag], {LINE_OFS_W{1'b0}}};
  assign resp_hit = i_l2_resp_valid && state[i_l2_resp_tag] == RESP_WAIT;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int e = 0; e < LRQ_ENTRY_SIZE; e++) begin
        state[e] <= FREE;
        line_q[e] <= '0;
      end
      lock_valid <= 1'b0;
      lock_idx <= '0;
      o_lrq_resolve_valid <= 1'b0;
      o_lrq_resolve_index_oh <= '0;
    end else begin
      for (int e = 0; e < LRQ_ENTRY_SIZE; e++) begin
        if (alloc[e]) begin
          state[e] <= REQ_WAIT;
          line_q[e] <= cur_line[e];
        end else if (o_l2_req_valid && i_l2_req_ready && o_l2_req_tag == IDX_W'(e)) begin
          state[e] <= RESP_WAIT;
        end else if (resp_hit && i_l2_resp_tag == IDX_W'(e)) begin
          state[e] <= FREE;
        end
      end
      lock_valid <= o_l2_req_valid && !i_l2_req_ready;
      lock_idx <= o_l2_req_tag;
      o_lrq_resolve_valid <= resp_hit;
      o_lrq_resolve_index_oh <= resp_hit ? LRQ_ENTRY_SIZE'(1) << i_l2_resp_tag : '0;
    end
  end
`ifdef MSRH_LRQ_PERF_CNT_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_perf_alloc_cnt <= '0;
      o_perf_full_cnt <= '0;
    end else begin
      o_perf_alloc_cnt <= o_perf_alloc_cnt + 32'($countones(o_resp_assigned));
      o_perf_full_cnt <= o_perf_full_cnt + 32'($countones(o_resp_full));
    end
  end
`else
  assign o_perf_alloc_cnt = '0;
  assign o_perf_full_cnt = '0;
`endif
endmodule

// File: tb/tb_msrh_lrq.sv
// tb_msrh_lrq: randomized and directed checks of msrh_lrq against a queue-level reference model
module tb_msrh_lrq;
  localparam int N = 8;
  localparam int P = 2;
  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  logic [P-1:0] i_req_valid;
  logic [P-1:0][39:0] i_req_paddr;
  logic [P-1:0] o_resp_full, o_resp_conflict, o_resp_assigned;
  logic [P-1:0][N-1:0] o_resp_index_oh;
  logic o_l2_req_valid, i_l2_req_ready, i_l2_resp_valid, o_lrq_resolve_valid;
  logic [39:0] o_l2_req_paddr;
  logic [2:0] o_l2_req_tag, i_l2_resp_tag;
  logic [N-1:0] o_lrq_resolve_index_oh;
  logic [31:0] o_perf_alloc_cnt, o_perf_full_cnt;
  msrh_lrq dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .i_req_paddr(i_req_paddr),
    .o_resp_full(o_resp_full), .o_resp_conflict(o_resp_conflict),
    .o_resp_assigned(o_resp_assigned), .o_resp_index_oh(o_resp_index_oh),
    .o_l2_req_valid(o_l2_req_valid), .i_l2_req_ready(i_l2_req_ready),
    .o_l2_req_paddr(o_l2_req_paddr), .o_l2_req_tag(o_l2_req_tag),
    .i_l2_resp_valid(i_l2_resp_valid), .i_l2_resp_tag(i_l2_resp_tag),
    .o_lrq_resolve_valid(o_lrq_resolve_valid), .o_lrq_resolve_index_oh(o_lrq_resolve_index_oh),
    .o_perf_alloc_cnt(o_perf_alloc_cnt), .o_perf_full_cnt(o_perf_full_cnt)
  );
  always #5 i_clk = ~i_clk;
  int errors = 0;
  int checks = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  int m_st[N];
  logic [33:0] m_ln[N];
  int m_lock;
  logic m_rv;
  logic [7:0] m_roh;
  logic [31:0] m_ac, m_fc;
  logic [P-1:0] e_full, e_conf, e_asg;
  logic [P-1:0][7:0] e_idx;
  int e_new[$];
  logic [33:0] e_newln[$];
  logic e_l2v;
  int e_tag;
  task automatic model_reset();
    foreach (m_st[e]) begin
      m_st[e] = 0;
      m_ln[e] = '0;
    end
    m_lock = -1;
    m_rv = 1'b0;
    m_roh = '0;
    m_ac = '0;
    m_fc = '0;
  endtask
  task automatic model_comb();
    bit used[N];
    logic [33:0] ln[N];
    logic [33:0] fulls[$];
    logic [33:0] l;
    int hit, fr;
    bit fh;
    foreach (used[e]) begin
      used[e] = m_st[e] != 0;
      ln[e] = m_ln[e];
    end
    e_full = '0;
    e_conf = '0;
    e_asg = '0;
    e_idx = '0;
    e_new.delete();
    e_newln.delete();
    for (int p = 0; p < P; p++) begin
      if (i_req_valid[p]) begin
        l = i_req_paddr[p][39:6];
        hit = -1;
        fr = -1;
        fh = 0;
        foreach (used[e]) if (used[e] && ln[e] == l) hit = e;
        for (int e = N - 1; e >= 0; e--) if (!used[e]) fr = e;
        foreach (fulls[i]) if (fulls[i] == l) fh = 1;
        if (hit >= 0) begin
          e_conf[p] = 1'b1;
          e_idx[p] = 8'(1 << hit);
        end else if (fh || fr < 0) begin
          e_full[p] = 1'b1;
          fulls.push_back(l);
        end else begin
          e_asg[p] = 1'b1;
          used[fr] = 1;
          ln[fr] = l;
          e_new.push_back(fr);
          e_newln.push_back(l);
        end
      end
    end
    e_l2v = 1'b0;
    e_tag = m_lock;
    for (int e = N - 1; e >= 0; e--)
      if (m_st[e] == 1) begin
        e_l2v = 1'b1;
        if (m_lock < 0) e_tag = e;
      end
  endtask
  task automatic drive(input logic [1:0] rv, input logic [39:0] a0, input logic [39:0] a1,
                       input logic rdy, input logic sv, input int st);
    i_req_valid = rv;
    i_req_paddr[0] = a0;
    i_req_paddr[1] = a1;
    i_l2_req_ready = rdy;
    i_l2_resp_valid = sv;
    i_l2_resp_tag = st[2:0];
    #1;
    model_comb();
    for (int p = 0; p < P; p++)
      check($sformatf("resp%0d", p), {o_resp_full[p], o_resp_conflict[p], o_resp_assigned[p], o_resp_index_oh[p]},
            {e_full[p], e_conf[p], e_asg[p], e_idx[p]});
    check("l2_req_valid", o_l2_req_valid, e_l2v);
    if (e_l2v) begin
      check("l2_req_tag", o_l2_req_tag, e_tag[2:0]);
      check("l2_req_paddr", o_l2_req_paddr, {m_ln[e_tag], 6'b0});
    end
  endtask
  task automatic tick();
    bit rh;
    rh = i_l2_resp_valid && m_st[i_l2_resp_tag] == 2;
    if (e_l2v && i_l2_req_ready) begin
      m_st[e_tag] = 2;
      m_lock = -1;
    end else m_lock = e_l2v ? e_tag : -1;
    if (rh) m_st[i_l2_resp_tag] = 0;
    foreach (e_new[i]) begin
      m_st[e_new[i]] = 1;
      m_ln[e_new[i]] = e_newln[i];
    end
    m_rv = rh;
    m_roh = rh ? 8'(1 << i_l2_resp_tag) : 8'h0;
    m_ac += 32'($countones(e_asg));
    m_fc += 32'($countones(e_full));
    @(negedge i_clk);
    check("resolve_valid", o_lrq_resolve_valid, m_rv);
    check("resolve_oh", o_lrq_resolve_index_oh, m_roh);
`ifdef MSRH_LRQ_PERF_CNT_EN
    check("perf_alloc", o_perf_alloc_cnt, m_ac);
    check("perf_full", o_perf_full_cnt, m_fc);
`else
    check("perf_alloc", o_perf_alloc_cnt, 0);
    check("perf_full", o_perf_full_cnt, 0);
`endif
  endtask
  task automatic idle(input logic rdy);
    drive(2'b00, '0, '0, rdy, 1'b0, 0);
    tick();
  endtask
  task automatic drain();
    int n, t;
    bit busy;
    n = 0;
    busy = 1;
    while (busy && n < 100) begin
      busy = 0;
      t = -1;
      for (int e = N - 1; e >= 0; e--) begin
        if (m_st[e] != 0) busy = 1;
        if (m_st[e] == 2) t = e;
      end
      if (busy) begin
        drive(2'b00, '0, '0, 1'b1, t >= 0, t >= 0 ? t : 0);
        tick();
        n++;
      end
    end
    check("drain_bound", n < 100, 1'b1);
  endtask
  function automatic logic [39:0] rand_addr();
    return 40'h6000_0000 + (40'($urandom_range(0, 11)) << 6) + 40'($urandom_range(0, 63));
  endfunction
  initial begin
    logic [39:0] a0, a1;
    int t;
    logic sv;
    i_req_valid = '0;
    i_req_paddr = '0;
    i_l2_req_ready = 1'b0;
    i_l2_resp_valid = 1'b0;
    i_l2_resp_tag = '0;
    model_reset();
    #12;
    check("rst_l2v", o_l2_req_valid, 1'b0);
    check("rst_rv", o_lrq_resolve_valid, 1'b0);
    check("rst_roh", o_lrq_resolve_index_oh, 8'h00);
    check("rst_perf", {o_perf_alloc_cnt, o_perf_full_cnt}, 64'h0);
    @(negedge i_clk);
    i_reset = 1'b0;
    drive(2'b01, 40'h1000_0040, '0, 1'b0, 1'b0, 0);
    check("t1_asg", {o_resp_assigned, o_resp_index_oh[0]}, {2'b01, 8'h00});
    tick();
    drive(2'b00, '0, '0, 1'b0, 1'b0, 0);
    check("t1_l2", {o_l2_req_valid, o_l2_req_tag, o_l2_req_paddr}, {1'b1, 3'd0, 40'h1000_0040});
    tick();
    idle(1'b1);
    drive(2'b00, '0, '0, 1'b0, 1'b1, 0);
    tick();
    check("t1_resolve", {o_lrq_resolve_valid, o_lrq_resolve_index_oh}, {1'b1, 8'h01});
    idle(1'b0);
    drive(2'b11, 40'h2000_0000, 40'h2000_0000, 1'b0, 1'b0, 0);
    check("t2_resp", {o_resp_assigned, o_resp_conflict, o_resp_index_oh[1]}, {2'b01, 2'b10, 8'h01});
    tick();
    drive(2'b00, '0, '0, 1'b1, 1'b0, 0);
    check("t2_l2", {o_l2_req_valid, o_l2_req_tag}, {1'b1, 3'd0});
    tick();
    drive(2'b00, '0, '0, 1'b1, 1'b0, 0);
    check("t2_single", o_l2_req_valid, 1'b0);
    tick();
    drain();
    for (int i = 0; i < 4; i++) begin
      a0 = 40'h3000_0000 + (40'(2 * i) << 6);
      a1 = 40'h3000_0000 + (40'(2 * i + 1) << 6);
      drive(2'b11, a0, a1, 1'b0, 1'b0, 0);
      tick();
    end
    drive(2'b01, 40'h3100_0000, '0, 1'b0, 1'b0, 0);
    check("t3_full", {o_resp_full, o_resp_index_oh[0]}, {2'b01, 8'h00});
    tick();
    repeat (8) idle(1'b1);
    drive(2'b00, '0, '0, 1'b0, 1'b1, 5);
    tick();
    drive(2'b01, 40'h3100_0000, '0, 1'b0, 1'b0, 0);
    check("t3_asg", o_resp_assigned, 2'b01);
    tick();
    drive(2'b00, '0, '0, 1'b0, 1'b0, 0);
    check("t3_tag", o_l2_req_tag, 3'd5);
    tick();
    drain();
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 40'h4000_0000 + (40'(i) << 6), '0, 1'b0, 1'b0, 0);
      tick();
    end
    repeat (3) idle(1'b1);
    drive(2'b00, '0, '0, 1'b0, 1'b1, 2);
    tick();
    drive(2'b01, 40'h4100_0000, '0, 1'b0, 1'b0, 0);
    tick();
    drive(2'b00, '0, '0, 1'b0, 1'b1, 0);
    check("t4_hold0", o_l2_req_tag, 3'd2);
    tick();
    drive(2'b01, 40'h4200_0000, '0, 1'b0, 1'b0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, '0, '0, 1'b0, 1'b0, 0);
      check("t4_hold", {o_l2_req_tag, o_l2_req_paddr}, {3'd2, 40'h4100_0000});
      tick();
    end
    drive(2'b00, '0, '0, 1'b1, 1'b0, 0);
    check("t4_acc", o_l2_req_tag, 3'd2);
    tick();
    drive(2'b00, '0, '0, 1'b0, 1'b0, 0);
    check("t4_next", {o_l2_req_tag, o_l2_req_paddr}, {3'd0, 40'h4200_0000});
    tick();
    drain();
    for (int i = 0; i < 2; i++) begin
      drive(2'b11, 40'h5000_0000 + (40'(2 * i) << 6), 40'h5000_0000 + (40'(2 * i + 1) << 6), 1'b0, 1'b0, 0);
      tick();
    end
    repeat (4) idle(1'b1);
    drive(2'b01, 40'h5000_00D0, '0, 1'b0, 1'b1, 3);
    check("t5_conf", {o_resp_conflict, o_resp_index_oh[0]}, {2'b01, 8'h08});
    tick();
    check("t5_resolve", {o_lrq_resolve_valid, o_lrq_resolve_index_oh}, {1'b1, 8'h08});
    drive(2'b01, 40'h5100_0000, '0, 1'b0, 1'b0, 0);
    check("t5_realloc", o_resp_assigned, 2'b01);
    tick();
    drive(2'b00, '0, '0, 1'b0, 1'b0, 0);
    check("t5_tag", o_l2_req_tag, 3'd3);
    tick();
    #2 i_reset = 1'b1;
    #1;
    model_reset();
    check("t6_l2v", o_l2_req_valid, 1'b0);
    check("t6_resolve", {o_lrq_resolve_valid, o_lrq_resolve_index_oh}, 9'h0);
    check("t6_perf", {o_perf_alloc_cnt, o_perf_full_cnt}, 64'h0);
    @(negedge i_clk);
    i_reset = 1'b0;
    drive(2'b00, '0, '0, 1'b0, 1'b1, 1);
    tick();
    check("t6_ignored", o_lrq_resolve_valid, 1'b0);
    repeat (3000) begin
      t = $urandom_range(0, 7);
      sv = 1'b0;
      if ($urandom_range(0, 3) == 0) sv = 1'b1;
      else if ($urandom_range(0, 1) == 1) begin
        for (int e = 0; e < N; e++)
          if (m_st[(t + e) % N] == 2 && !sv) begin
            sv = 1'b1;
            t = (t + e) % N;
          end
      end
      drive(2'($urandom), rand_addr(), rand_addr(), 1'($urandom), sv, t);
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/msrh_lrq.md
# msrh_lrq

Load Request Queue (LRQ) for the LSU. It allocates one entry per outstanding L1D line miss reported by the LSU EX2 stage, and returns ASSIGNED, CONFLICT or FULL to the requesting pipe in the same cycle. It issues each miss once to L2 and, on the L2 response, broadcasts a one-hot resolve that wakes load-queue entries parked in LRQ_HAZ. It sits between the LSU EX2 pipes and the L2 request/response port.

## Interface

Clocking decision: one clock; reset is asynchronous and active-high.

Parameters:
- LRQ_ENTRY_SIZE, 8, number of entries; power of two, at least 2.
- LSU_INST_NUM, 2, number of LSU pipes.
- PADDR_W, 40, physical address width.
- LINE_OFS_W, 6, line offset bits; line address is paddr[PADDR_W-1:LINE_OFS_W].

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  async active-high reset.
- i_req_valid  in  LSU_INST_NUM  per-pipe miss request from EX2.
- i_req_paddr  in  PADDR_W x LSU_INST_NUM  per-pipe miss address.
- o_resp_full  out  LSU_INST_NUM  no entry was available.
- o_resp_conflict  out  LSU_INST_NUM  the line is already in flight.
- o_resp_assigned  out  LSU_INST_NUM  a new entry was allocated.
- o_resp_index_oh  out  LRQ_ENTRY_SIZE x LSU_INST_NUM  conflicting entry on CONFLICT, otherwise 0.
- o_l2_req_valid  out  1  L2 refill request.
- i_l2_req_ready  in  1  L2 accepts the request.
- o_l2_req_paddr  out  PADDR_W  line-aligned address (offset bits 0).
- o_l2_req_tag  out  $clog2(LRQ_ENTRY_SIZE)  entry index.
- i_l2_resp_valid  in  1  refill complete.
- i_l2_resp_tag  in  $clog2(LRQ_ENTRY_SIZE)  entry being completed.
- o_lrq_resolve_valid  out  1  resolve broadcast.
- o_lrq_resolve_index_oh  out  LRQ_ENTRY_SIZE  entry that was resolved.
- o_perf_alloc_cnt  out  32  total allocations.
- o_perf_full_cnt  out  32  total FULL responses.

## Operation

- Per-entry states: FREE, REQ_WAIT, RESP_WAIT.
  - FREE -> REQ_WAIT on allocation.
  - REQ_WAIT -> RESP_WAIT on L2 handshake.
  - RESP_WAIT -> FREE on an i_l2_resp_valid whose tag matches the entry.
- Each entry holds a valid bit (state != FREE) and the line address.
- Pipes are evaluated in order: pipe 0 first, then pipe 1, and so on.
- For each valid request, exactly one resp bit is asserted; with i_req_valid=0 all resp bits are 0.
  - CONFLICT: the line address matches a non-FREE entry, or matches a lower pipe allocating in the same cycle. o_resp_index_oh is that entry.
  - Otherwise, if a free entry remains after lower pipes' allocations, the pipe takes the lowest-index free entry. Response is ASSIGNED with index_oh=0, and the pipe reruns to learn the index.
  - Otherwise FULL, with index_oh=0.
- Any pipe in the same cycle that hits a line a lower pipe found FULL is also FULL.
- L2 request: select the lowest-index REQ_WAIT entry.
  - Once o_l2_req_valid is high, paddr and tag stay stable until i_l2_req_ready, even if a lower-index entry enters REQ_WAIT.
- L2 response:
  - Register o_lrq_resolve_valid=1 and o_lrq_resolve_index_oh=onehot(tag) for exactly one cycle.
  - The entry becomes FREE on the same edge.
  - A response whose tag names an entry not in RESP_WAIT is ignored; no resolve is produced.

## Timing

- resp outputs are combinational from i_req_*; allocation takes effect at the next edge.
- Resolve latency: one cycle after i_l2_resp_valid.
- A request in the same cycle as the response for its line gets CONFLICT, because the entry is still valid. The resolve arrives the next cycle, so the LDQ moves LRQ_HAZ -> READY one cycle later.
- An entry freed by a response can be allocated on the next cycle.
- Minimum allocation-to-L2-request latency is one cycle: the entry is in REQ_WAIT on the next cycle, with valid combinational from state.
- Reset values: all entries FREE; o_l2_req_valid=0; o_lrq_resolve_valid=0; o_lrq_resolve_index_oh=0; perf counters 0.
- Reset mid-operation drops all in-flight misses. L2 responses arriving after reset for now-FREE entries are ignored.

## Configuration

- MSRH_LRQ_PERF_CNT_EN defined:
  - o_perf_alloc_cnt increments by the number of ASSIGNED responses each cycle.
  - o_perf_full_cnt increments by the number of FULL responses each cycle.
  - Both counters wrap modulo 2^32.
- MSRH_LRQ_PERF_CNT_EN undefined: both counter ports are tied to 0, with no counter flops.

## Test plan

- Single miss:
  - Pipe0 request with paddr 0x1000_0040 -> ASSIGNED, index_oh=0.
  - Next cycle: o_l2_req_valid=1, paddr 0x1000_0040, tag 0.
  - Ready, then response tag 0 -> next cycle resolve_valid=1, index_oh=0x01.
- Same-cycle dual request, both pipes paddr 0x2000_0000 -> pipe0 ASSIGNED, pipe1 CONFLICT with index_oh=0x01. Only one L2 request is issued.
- Fill all 8 entries, then request a new line -> FULL with index_oh=0. After one response, the next-cycle request -> ASSIGNED into the freed index.
- Hold i_l2_req_ready=0 for 5 cycles with entries 2 and 0 entering REQ_WAIT in that order -> entry 2's paddr/tag stay stable until ready, then entry 0 is requested.
- Response for tag 3 in the same cycle as a pipe0 request for entry 3's line -> CONFLICT with index_oh=0x08. Next cycle: resolve index_oh=0x08 and entry 3 is FREE.
- Assert i_reset with 4 entries in flight -> all outputs return to their reset values. A subsequent response for tag 1 produces no resolve.
